// File: rtl/twin_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : twin_reg_pkg
//  Purpose  : Shared defaults, encodings and the arbitration state type for
//             the twin register arbiter.
//  Contents : DEF_WIDTH / DEF_CNT_W defaults, target-select, owner and
//             favoured-side encodings, rr_state_t enum.
//  Revision : 1.0  initial release
// ============================================================================
package twin_reg_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;

  // Target register select
  localparam logic SEL_REG1 = 1'b0;
  localparam logic SEL_REG2 = 1'b1;

  // Last-writer encoding
  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  // Round-robin favoured side
  localparam logic FAV_A = 1'b0;
  localparam logic FAV_B = 1'b1;

  typedef enum logic {
    S_FAV_A = FAV_A,
    S_FAV_B = FAV_B
  } rr_state_t;

endpackage : twin_reg_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-way round-robin arbiter. Grants pass straight through when
//             there is no conflict; on a conflict the favoured side wins and
//             the favour moves to the loser at the next edge.
//  Ports    : clk       in  clock, rising edge
//             rst       in  asynchronous active-high reset
//             r0, r1    in  requests
//             conflict  in  both requests target the same resource
//             g0, g1    out grants (combinational, 0 while rst=1)
//             ptr       out favoured side (0 = r0, 1 = r1)
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2
  import twin_reg_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic r0,
  input  logic r1,
  input  logic conflict,
  output logic g0,
  output logic g1,
  output logic ptr
);

  rr_state_t r_state;

  // Favour moves to the loser only on a conflict cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FAV_A;
    end else if (conflict) begin
      case (r_state)
        S_FAV_A: r_state <= S_FAV_B;
        S_FAV_B: r_state <= S_FAV_A;
        default: r_state <= S_FAV_A;
      endcase
    end
  end

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      if (conflict) begin
        g0 = r0 && (r_state == S_FAV_A);
        g1 = r1 && (r_state == S_FAV_B);
      end else begin
        g0 = r0;
        g1 = r1;
      end
    end
  end

  assign ptr = r_state;

endmodule : rr_arb2
`default_nettype wire

// File: rtl/twin_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : twin_reg_arbiter
//  Purpose  : Shares the reg1/reg2 twin register pair between requesters A
//             and B. Same-register collisions are resolved round-robin;
//             writes to different registers proceed in parallel. Tracks a
//             wrapping write count and last writer per register.
//  Ports    : clk, rst                 clock / async active-high reset
//             req_a, sel_a, d_a, gnt_a requester A (sel: 0=reg1, 1=reg2)
//             req_b, sel_b, d_b, gnt_b requester B
//             q1, q2                   register contents
//             wcnt1, wcnt2             write counts mod 2^CNT_W
//             owner1, owner2           last writer (0=A, 1=B)
//  Revision : 1.0  initial release
// ============================================================================
module twin_reg_arbiter
  import twin_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             sel_a,
  input  logic [WIDTH-1:0] d_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic             sel_b,
  input  logic [WIDTH-1:0] d_b,
  output logic             gnt_b,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [CNT_W-1:0] wcnt1,
  output logic [CNT_W-1:0] wcnt2,
  output logic             owner1,
  output logic             owner2
);

  logic             w_conflict;
  logic             w_gnt_a;
  logic             w_gnt_b;
  logic             w_rr_ptr;
  logic             w_wr1;
  logic             w_wr2;
  logic             w_src1_b;
  logic             w_src2_b;

  logic [WIDTH-1:0] r_q1;
  logic [WIDTH-1:0] r_q2;
  logic [CNT_W-1:0] r_wcnt1;
  logic [CNT_W-1:0] r_wcnt2;
  logic             r_owner1;
  logic             r_owner2;

  assign w_conflict = req_a && req_b && (sel_a == sel_b);

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .r0       (req_a),
    .r1       (req_b),
    .conflict (w_conflict),
    .g0       (w_gnt_a),
    .g1       (w_gnt_b),
    .ptr      (w_rr_ptr)
  );

  assign gnt_a = w_gnt_a;
  assign gnt_b = w_gnt_b;

  // At most one granted write lands on each register per cycle.
  assign w_wr1 = (w_gnt_a && (sel_a == SEL_REG1)) || (w_gnt_b && (sel_b == SEL_REG1));
  assign w_wr2 = (w_gnt_a && (sel_a == SEL_REG2)) || (w_gnt_b && (sel_b == SEL_REG2));

  // Source of each write: on a conflict the favoured side is the writer,
  // otherwise whichever granted side targets that register.
  assign w_src1_b = w_conflict ? (w_rr_ptr == FAV_B) : (w_gnt_b && (sel_b == SEL_REG1));
  assign w_src2_b = w_conflict ? (w_rr_ptr == FAV_B) : (w_gnt_b && (sel_b == SEL_REG2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q1     <= '0;
      r_q2     <= '0;
      r_wcnt1  <= '0;
      r_wcnt2  <= '0;
      r_owner1 <= OWN_A;
      r_owner2 <= OWN_A;
    end else begin
      if (w_wr1) begin
        r_q1     <= w_src1_b ? d_b : d_a;
        r_wcnt1  <= r_wcnt1 + CNT_W'(1);
        r_owner1 <= w_src1_b ? OWN_B : OWN_A;
      end
      if (w_wr2) begin
        r_q2     <= w_src2_b ? d_b : d_a;
        r_wcnt2  <= r_wcnt2 + CNT_W'(1);
        r_owner2 <= w_src2_b ? OWN_B : OWN_A;
      end
    end
  end

  assign q1     = r_q1;
  assign q2     = r_q2;
  assign wcnt1  = r_wcnt1;
  assign wcnt2  = r_wcnt2;
  assign owner1 = r_owner1;
  assign owner2 = r_owner2;

endmodule : twin_reg_arbiter
`default_nettype wire

// File: tb/tb_twin_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_twin_reg_arbiter
//  Purpose  : Self-checking bench for twin_reg_arbiter with a behavioural
//             reference model (register array, counters, owners, favour).
//  Revision : 1.0  initial release
// ============================================================================
module tb_twin_reg_arbiter;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             req_a, sel_a, req_b, sel_b;
  logic [WIDTH-1:0] d_a, d_b;
  logic             gnt_a, gnt_b;
  logic [WIDTH-1:0] q1, q2;
  logic [CNT_W-1:0] wcnt1, wcnt2;
  logic             owner1, owner2;

  int tests;
  int fails;

  // Reference model state
  int m_q   [2];
  int m_cnt [2];
  int m_own [2];
  int m_fav;          // 0 = A wins next conflict, 1 = B
  int e_ga, e_gb;

  twin_reg_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .req_a  (req_a),
    .sel_a  (sel_a),
    .d_a    (d_a),
    .gnt_a  (gnt_a),
    .req_b  (req_b),
    .sel_b  (sel_b),
    .d_b    (d_b),
    .gnt_b  (gnt_b),
    .q1     (q1),
    .q2     (q2),
    .wcnt1  (wcnt1),
    .wcnt2  (wcnt2),
    .owner1 (owner1),
    .owner2 (owner2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_q[i] = 0; m_cnt[i] = 0; m_own[i] = 0;
    end
    m_fav = 0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".q1"},     32'(q1),     32'(m_q[0]));
    chk({tag, ".q2"},     32'(q2),     32'(m_q[1]));
    chk({tag, ".wcnt1"},  32'(wcnt1),  32'(m_cnt[0]));
    chk({tag, ".wcnt2"},  32'(wcnt2),  32'(m_cnt[1]));
    chk({tag, ".owner1"}, 32'(owner1), 32'(m_own[0]));
    chk({tag, ".owner2"}, 32'(owner2), 32'(m_own[1]));
  endtask

  // One cycle: drive inputs, check grants mid-cycle, clock, check state.
  // Called just after a rising edge.
  task automatic step(input string tag,
                      input logic ra, input logic sa, input logic [7:0] da,
                      input logic rb, input logic sb, input logic [7:0] db);
    int ta, tb_;
    req_a = ra; sel_a = sa; d_a = da;
    req_b = rb; sel_b = sb; d_b = db;
    ta = sa ? 1 : 0;
    tb_ = sb ? 1 : 0;
    // Grant rule from the requester's point of view
    if (ra && rb && ta == tb_) begin
      e_ga = (m_fav == 0) ? 1 : 0;
      e_gb = 1 - e_ga;
    end else begin
      e_ga = ra ? 1 : 0;
      e_gb = rb ? 1 : 0;
    end
    @(negedge clk);
    chk({tag, ".gnt_a"}, 32'(gnt_a), 32'(e_ga));
    chk({tag, ".gnt_b"}, 32'(gnt_b), 32'(e_gb));
    @(posedge clk);
    if (ra && rb && ta == tb_) m_fav = e_ga;   // favour passes to the loser
    if (e_ga == 1) begin
      m_q[ta] = int'(da); m_cnt[ta] = (m_cnt[ta] + 1) % (1 << CNT_W); m_own[ta] = 0;
    end
    if (e_gb == 1) begin
      m_q[tb_] = int'(db); m_cnt[tb_] = (m_cnt[tb_] + 1) % (1 << CNT_W); m_own[tb_] = 1;
    end
    #1;
    chk_state(tag);
  endtask

  initial begin
    logic       pa, psa, pb, psb;
    logic [7:0] pda, pdb;
    int         cnt_before;

    tests = 0;
    fails = 0;
    model_reset();

    // Reset with both requests asserted: grants must stay low
    rst = 1'b1;
    req_a = 1'b1; sel_a = 1'b0; d_a = 8'hFF;
    req_b = 1'b1; sel_b = 1'b1; d_b = 8'hEE;
    #2;
    chk("rst.gnt_a", 32'(gnt_a), 32'd0);
    chk("rst.gnt_b", 32'(gnt_b), 32'd0);
    chk_state("rst");
    #8;
    rst = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    @(posedge clk); #1;
    chk_state("post_rst");

    // Single write to reg1
    step("single_a", 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00);
    chk("single_a.q1_lit", 32'(q1), 32'hA5);

    // Parallel writes to different registers
    step("parallel", 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 8'h22);
    chk("parallel.q2_lit", 32'(q2), 32'h22);
    chk("parallel.own2_lit", 32'(owner2), 32'd1);

    // Four back-to-back conflicts on reg2: A,B,A,B
    cnt_before = int'(wcnt2);
    for (int i = 0; i < 4; i++) begin
      step("conflict", 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 8'h44);
      chk("conflict.q2_lit", 32'(q2), (i % 2 == 0) ? 32'h33 : 32'h44);
    end
    chk("conflict.wcnt2_delta", 32'((int'(wcnt2) - cnt_before) & 15), 32'd4);

    // Sixteen writes to reg1: counter wraps back to its start value
    cnt_before = int'(wcnt1);
    for (int i = 0; i < 16; i++)
      step("wrap", 1'b1, 1'b0, 8'(i), 1'b0, 1'b0, 8'h00);
    chk("wrap.wcnt1", 32'(wcnt1), 32'(cnt_before));

    // Randomized traffic; a requester that was not granted holds its request
    pa = 1'b0; pb = 1'b0; psa = 1'b0; psb = 1'b0; pda = 8'h00; pdb = 8'h00;
    for (int i = 0; i < 300; i++) begin
      if (!pa) begin
        pa = 1'($urandom_range(0, 1)); psa = 1'($urandom_range(0, 1)); pda = 8'($urandom);
      end
      if (!pb) begin
        pb = 1'($urandom_range(0, 1)); psb = 1'($urandom_range(0, 1)); pdb = 8'($urandom);
      end
      step("rand", pa, psa, pda, pb, psb, pdb);
      if (e_ga == 1) pa = 1'b0;
      if (e_gb == 1) pb = 1'b0;
    end

    // Leave favour on B, then reset mid-conflict
    step("pre_rst", 1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 8'h66);
    if (m_fav == 0)
      step("pre_rst2", 1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 8'h66);
    req_a = 1'b1; sel_a = 1'b1; d_a = 8'h77;
    req_b = 1'b1; sel_b = 1'b1; d_b = 8'h88;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst.gnt_a", 32'(gnt_a), 32'd0);
    chk("midrst.gnt_b", 32'(gnt_b), 32'd0);
    chk_state("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    @(posedge clk); #1;
    step("after_rst", 1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 8'h88);
    chk("after_rst.q2_lit", 32'(q2), 32'h77);
    chk("after_rst.own2_lit", 32'(owner2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_twin_reg_arbiter
`default_nettype wire
